// File: rtl/debounce_scan_arbiter.sv
// rtl/debounce_scan_arbiter.sv - shared-timer debouncer with round-robin scan and valid/ready event output
//
// Purpose:
//   One debounce timer serves Num_Inputs raw inputs. A rising edge on a
//   channel marks it pending. The arbiter grants the timer round-robin to one
//   pending channel at a time. After the debounce window the level is checked
//   again, and a confirmed press produces one event on a valid/ready handshake.
//
// Ports:
//   CLK          in   system clock, rising edge
//   Reset_N      in   asynchronous active-low reset
//   Signal_In    in   [Num_Inputs] raw levels, asynchronous to CLK
//   Event_Ready  in   consumer accepts the presented event
//   Event_Valid  out  event presented, held until accepted
//   Event_Id     out  [Id_Width] channel of the presented event
//   Busy         out  FSM not idle
//   Drop_Count   out  [8] saturating glitch-reject count
//                     (present only with DEBOUNCE_SCAN_DROP_COUNT_EN defined)

module debounce_scan_arbiter #(
  parameter int          Num_Inputs      = 4,
  parameter int          Id_Width        = 2,
  parameter logic [21:0] Debounce_Length = 22'd2500000
) (
  input  logic                  CLK,
  input  logic                  Reset_N,
  input  logic [Num_Inputs-1:0] Signal_In,
  input  logic                  Event_Ready,
  output logic                  Event_Valid,
  output logic [Id_Width-1:0]   Event_Id,
  output logic                  Busy
`ifdef DEBOUNCE_SCAN_DROP_COUNT_EN
  ,
  output logic [7:0]            Drop_Count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    EMIT  = 2'd2
  } state_t;

  // A zero-length window still needs one COUNT cycle to sample the level.
  localparam logic [21:0] LoadValue = (Debounce_Length == 22'd0) ? 22'd1 : Debounce_Length;

  logic [Num_Inputs-1:0] sync1, sync2, sync2_prev;
  logic [Num_Inputs-1:0] pending, held, pending_d;
  logic [Num_Inputs-1:0] rise, granted, grant_mask, accept_mask;
  logic [1:0]            settle;
  logic                  armed;

  state_t                state, state_d;
  logic [21:0]           timer, timer_d;
  logic [Id_Width-1:0]   grant, grant_d, rr_ptr, rr_ptr_d, pick;
  logic                  any_pending, grant_fire, accept;
  logic                  valid, valid_d;
  int                    scan_idx;

  // Synchronizers. Edge detection stays masked until the pipeline holds
  // three real samples after reset, so an input that is already high when
  // reset is released is not mistaken for a fresh press.
  always_ff @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N) begin
      sync1      <= '0;
      sync2      <= '0;
      sync2_prev <= '0;
      settle     <= '0;
    end else begin
      sync1      <= Signal_In;
      sync2      <= sync1;
      sync2_prev <= sync2;
      if (!armed) settle <= settle + 2'd1;
    end
  end

  assign armed = (settle == 2'd3);
  assign rise  = sync2 & ~sync2_prev & {Num_Inputs{armed}};

  // Round-robin pick: walk downwards so the last hit is the lowest offset
  // from rr_ptr, i.e. the first pending channel at or after the pointer.
  always_comb begin
    pick        = '0;
    any_pending = 1'b0;
    scan_idx    = 0;
    for (int k = Num_Inputs - 1; k >= 0; k--) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= Num_Inputs) scan_idx = scan_idx - Num_Inputs;
      if (pending[scan_idx]) begin
        pick        = Id_Width'(scan_idx);
        any_pending = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N) begin
      state  <= IDLE;
      timer  <= '0;
      grant  <= '0;
      rr_ptr <= '0;
      valid  <= 1'b0;
    end else begin
      state  <= state_d;
      timer  <= timer_d;
      grant  <= grant_d;
      rr_ptr <= rr_ptr_d;
      valid  <= valid_d;
    end
  end

  // Event_Valid is registered, so it rises one cycle after entering EMIT.
  always_comb begin
    state_d    = state;
    timer_d    = timer;
    grant_d    = grant;
    rr_ptr_d   = rr_ptr;
    valid_d    = valid;
    grant_fire = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (any_pending) begin
          grant_fire = 1'b1;
          grant_d    = pick;
          rr_ptr_d   = (int'(pick) == Num_Inputs - 1) ? '0 : pick + Id_Width'(1);
          timer_d    = LoadValue;
          state_d    = COUNT;
        end
      end
      COUNT: begin
        if (timer == 22'd1) begin
          state_d = sync2[grant] ? EMIT : IDLE;
        end else begin
          timer_d = timer - 22'd1;
        end
      end
      EMIT: begin
        valid_d = 1'b1;
        if (valid && Event_Ready) begin
          accept  = 1'b1;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    granted     = '0;
    grant_mask  = '0;
    accept_mask = '0;
    for (int i = 0; i < Num_Inputs; i++) begin
      granted[i]     = (state != IDLE) && (int'(grant) == i);
      grant_mask[i]  = grant_fire && (int'(pick) == i);
      accept_mask[i] = accept && (int'(grant) == i);
    end
  end

  // An edge only arms an idle, released, not-in-service channel; the grant
  // consumes the pending flag.
  assign pending_d = (pending & ~grant_mask) | (rise & ~held & ~granted & ~pending);

  always_ff @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N) begin
      pending <= '0;
      held    <= '0;
    end else begin
      pending <= pending_d;
      held    <= (held | accept_mask) & sync2;
    end
  end

  assign Event_Valid = valid;
  assign Event_Id    = grant;
  assign Busy        = (state != IDLE);

`ifdef DEBOUNCE_SCAN_DROP_COUNT_EN
  logic       reject;
  logic [7:0] drops;

  assign reject = (state == COUNT) && (timer == 22'd1) && !sync2[grant];

  always_ff @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N) begin
      drops <= '0;
    end else if (reject && (drops != 8'hFF)) begin
      drops <= drops + 8'd1;
    end
  end

  assign Drop_Count = drops;
`endif

endmodule

// File: tb/tb_debounce_scan_arbiter.sv
// tb/tb_debounce_scan_arbiter.sv - directed and randomized bench for debounce_scan_arbiter
module tb_debounce_scan_arbiter;
  localparam int L = 8;

  logic       CLK = 1'b0;
  logic       Reset_N = 1'b0;
  logic [3:0] Signal_In = '0;
  logic       Event_Ready = 1'b1;
  logic       Event_Valid;
  logic [1:0] Event_Id;
  logic       Busy;
`ifdef DEBOUNCE_SCAN_DROP_COUNT_EN
  logic [7:0] Drop_Count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  debounce_scan_arbiter #(
    .Num_Inputs(4),
    .Id_Width(2),
    .Debounce_Length(22'd8)
  ) dut (
    .CLK(CLK),
    .Reset_N(Reset_N),
    .Signal_In(Signal_In),
    .Event_Ready(Event_Ready),
    .Event_Valid(Event_Valid),
    .Event_Id(Event_Id),
    .Busy(Busy)
`ifdef DEBOUNCE_SCAN_DROP_COUNT_EN
    ,
    .Drop_Count(Drop_Count)
`endif
  );

  // Reference model, advanced once per clock edge from absolute cycle times.
  logic [3:0] hist[$];
  logic [3:0] m_pend, m_held;
  int         m_cyc, m_mode, m_gid, m_ptr, m_finish, m_drops;
  logic       m_valid;

  logic [3:0] sig;
  logic       rdy;
  logic [1:0] got[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_pend = '0; m_held = '0;
    m_cyc = 0; m_mode = 0; m_gid = 0; m_ptr = 0; m_finish = 0; m_drops = 0;
    m_valid = 1'b0;
  endtask

  // Input level sampled at edge k after reset (edge 1 is the first).
  function automatic logic [3:0] lvl(input int k);
    return (k >= 1) ? hist[k-1] : 4'b0000;
  endfunction

  task automatic model_update(input logic [3:0] s, input logic r);
    logic [3:0] now_lvl, old_lvl, new_pend;
    logic       acc;
    int         found, j;
    m_cyc++;
    hist.push_back(s);
    now_lvl  = lvl(m_cyc - 2);
    old_lvl  = lvl(m_cyc - 3);
    acc      = m_valid && r;
    new_pend = m_pend;
    for (int i = 0; i < 4; i++) begin
      if (m_cyc >= 4 && now_lvl[i] && !old_lvl[i] && !m_held[i] && !m_pend[i] &&
          !(m_mode != 0 && m_gid == i))
        new_pend[i] = 1'b1;
      m_held[i] = (m_held[i] || (acc && m_gid == i)) && now_lvl[i];
    end
    case (m_mode)
      0: if (m_pend != 4'b0000) begin
        found = -1;
        for (int k = 0; k < 4; k++) begin
          j = (m_ptr + k) % 4;
          if (found < 0 && m_pend[j]) found = j;
        end
        m_gid = found;
        new_pend[found] = 1'b0;
        m_ptr = (found + 1) % 4;
        m_finish = m_cyc + L;
        m_mode = 1;
      end
      1: if (m_cyc == m_finish) begin
        if (now_lvl[m_gid]) m_mode = 2;
        else begin
          m_mode = 0;
          if (m_drops < 255) m_drops++;
        end
      end
      default: begin
        if (acc) begin m_valid = 1'b0; m_mode = 0; end
        else m_valid = 1'b1;
      end
    endcase
    m_pend = new_pend;
  endtask

  task automatic step();
    if (Event_Valid && rdy) got.push_back(Event_Id);
    Signal_In   = sig;
    Event_Ready = rdy;
    model_update(sig, rdy);
    @(posedge CLK);
    @(negedge CLK);
    check("valid", Event_Valid, m_valid);
    check("id", Event_Id, m_gid[1:0]);
    check("busy", Busy, m_mode != 0);
`ifdef DEBOUNCE_SCAN_DROP_COUNT_EN
    check("drop_count", Drop_Count, m_drops);
`endif
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    sig = '0;
    rdy = 1'b1;
    Signal_In = '0;
    Reset_N = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    check("rst_valid", Event_Valid, 0);
    check("rst_id", Event_Id, 0);
    check("rst_busy", Busy, 0);
    Reset_N = 1'b1;
    run(5);
  endtask

  initial begin
    int lat;
    bit found;

    do_reset();

    // Clean press on channel 2 with latency and pulse width.
    got.delete();
    sig[2] = 1'b1;
    step();
    lat = 0; found = 0;
    for (int i = 1; i <= 30 && !found; i++) begin
      step();
      if (Event_Valid) begin lat = i; found = 1; end
    end
    check("press_latency", lat, L + 4);
    check("press_id", Event_Id, 2);
    step();
    check("pulse_len", Event_Valid, 0);
    run(30);
    check("held_no_repeat", got.size(), 1);
    sig[2] = 1'b0; run(5);
    sig[2] = 1'b1; run(20);
    check("repress_count", got.size(), 2);
    if (got.size() == 2) check("repress_id", got[1], 2);
    sig[2] = 1'b0; run(5);

    // Glitch on channel 1.
    sig[1] = 1'b1; run(3);
    sig[1] = 1'b0; run(20);
    check("glitch_no_event", got.size(), 2);
`ifdef DEBOUNCE_SCAN_DROP_COUNT_EN
    check("glitch_drop", Drop_Count, 1);
`endif

    // Contention with pointer 0, then pointer 1.
    do_reset();
    got.delete();
    sig = 4'b1001; run(40);
    check("cont0_count", got.size(), 2);
    if (got.size() == 2) begin
      check("cont0_first", got[0], 0);
      check("cont0_second", got[1], 3);
    end
    sig = 4'b0000; run(5);
    sig = 4'b0001; run(20);
    sig = 4'b0000; run(5);
    got.delete();
    sig = 4'b1001; run(40);
    check("cont1_count", got.size(), 2);
    if (got.size() == 2) begin
      check("cont1_first", got[0], 3);
      check("cont1_second", got[1], 0);
    end
    sig = 4'b0000; run(5);

    // Backpressure: 20 stalled cycles, channel 1 queued meanwhile.
    got.delete();
    rdy = 1'b0;
    sig = 4'b0100;
    for (int i = 0; i < 40 && !Event_Valid; i++) step();
    check("bp_valid_seen", Event_Valid, 1);
    for (int i = 0; i < 19; i++) begin
      if (i == 3) sig[1] = 1'b1;
      step();
      check("bp_hold_valid", Event_Valid, 1);
      check("bp_hold_id", Event_Id, 2);
    end
    rdy = 1'b1;
    step();
    check("bp_release", Event_Valid, 0);
    run(30);
    check("bp_count", got.size(), 2);
    if (got.size() == 2) begin
      check("bp_first", got[0], 2);
      check("bp_queued", got[1], 1);
    end
    sig = 4'b0000; run(5);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 15) == 0) sig[c] = ~sig[c];
      rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    rdy = 1'b1;
    sig = 4'b0000; run(60);

    // Reset during COUNT on channel 2, input left high.
    sig = 4'b0100;
    for (int i = 0; i < 10 && !Busy; i++) step();
    run(3);
    check("pre_reset_busy", Busy, 1);
    #2 Reset_N = 1'b0;
    #1;
    check("async_rst_valid", Event_Valid, 0);
    check("async_rst_id", Event_Id, 0);
    check("async_rst_busy", Busy, 0);
    model_reset();
    @(negedge CLK);
    Reset_N = 1'b1;
    got.delete();
    run(40);
    check("no_replay", got.size(), 0);
    sig[2] = 1'b0; run(5);
    sig[2] = 1'b1; run(20);
    check("after_reset_count", got.size(), 1);
    if (got.size() == 1) check("after_reset_id", got[0], 2);
    sig = 4'b0000; run(5);

`ifdef DEBOUNCE_SCAN_DROP_COUNT_EN
    // 300 glitches saturate the drop counter.
    do_reset();
    for (int g = 0; g < 300; g++) begin
      sig[1] = 1'b1; run(2);
      sig[1] = 1'b0; run(14);
    end
    check("drop_saturate", Drop_Count, 255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
